// File: rtl/bfloat_to_int.sv
// rtl/bfloat_to_int.sv - iterative bfloat16 to signed integer converter, round-to-nearest-even
module bfloat_to_int #(
  parameter int INT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] out_data,
  output logic             out_overflow,
  output logic             out_invalid
);

  if (INT_W < 9 || INT_W > 32) begin : g_bad_width
    $error("bfloat_to_int: INT_W must lie in 9..32");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  // Smallest biased exponent whose magnitude no longer fits in INT_W-1 bits.
  localparam logic [8:0]       SAT_E   = 9'(127 + INT_W - 1);
  localparam logic [INT_W-1:0] POS_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] NEG_MIN = {1'b1, {(INT_W-1){1'b0}}};

  state_t           state_q, state_d;
  logic [INT_W-1:0] mag_q, mag_d;
  logic [INT_W-1:0] data_q, data_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             left_q, left_d;
  logic             sign_q, sign_d;
  logic             g_q, g_d, r_q, r_d, s_q, s_d;
  logic             ovf_q, ovf_d;
  logic             inv_q, inv_d;

  logic             in_sign;
  logic [7:0]       in_exp;
  logic [6:0]       in_frac;
  logic             round_up;
  logic [INT_W-1:0] rounded;

  assign in_sign  = in_data[15];
  assign in_exp   = in_data[14:7];
  assign in_frac  = in_data[6:0];
  assign round_up = g_q & (r_q | s_q | mag_q[0]);
  assign rounded  = mag_q + {{(INT_W-1){1'b0}}, round_up};

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    sign_d  = sign_q;
    g_d     = g_q;
    r_d     = r_q;
    s_d     = s_q;
    ovf_d   = ovf_q;
    inv_d   = inv_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ovf_d   = 1'b0;
          inv_d   = 1'b0;
          sign_d  = in_sign;
          g_d     = 1'b0;
          r_d     = 1'b0;
          s_d     = 1'b0;
          left_d  = 1'b0;
          cnt_d   = 5'd0;
          mag_d   = {{(INT_W-8){1'b0}}, 1'b1, in_frac};
          state_d = DONE;
          if (in_exp == 8'd0) begin
            data_d = '0;
          end else if (in_exp == 8'hFF && |in_frac) begin
            data_d = '0;
            inv_d  = 1'b1;
          end else if ({1'b0, in_exp} >= SAT_E) begin
            // -2^(INT_W-1) itself is representable and is not an overflow.
            data_d = in_sign ? NEG_MIN : POS_MAX;
            ovf_d  = !(in_sign && {1'b0, in_exp} == SAT_E && !(|in_frac));
          end else if (in_exp >= 8'd134) begin
            left_d  = 1'b1;
            cnt_d   = 5'(in_exp - 8'd134);
            state_d = (in_exp == 8'd134) ? ROUND : SHIFT;
          end else begin
            cnt_d   = (in_exp <= 8'd125) ? 5'd9 : 5'(8'd134 - in_exp);
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        cnt_d = cnt_q - 5'd1;
        if (left_q) begin
          mag_d = mag_q << 1;
        end else begin
          mag_d = mag_q >> 1;
          g_d   = mag_q[0];
          r_d   = g_q;
          s_d   = s_q | r_q;
        end
        if (cnt_q == 5'd1) state_d = ROUND;
      end
      ROUND: begin
        data_d  = sign_q ? -rounded : rounded;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          ovf_d   = 1'b0;
          inv_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mag_q   <= '0;
      data_q  <= '0;
      cnt_q   <= 5'd0;
      left_q  <= 1'b0;
      sign_q  <= 1'b0;
      g_q     <= 1'b0;
      r_q     <= 1'b0;
      s_q     <= 1'b0;
      ovf_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      sign_q  <= sign_d;
      g_q     <= g_d;
      r_q     <= r_d;
      s_q     <= s_d;
      ovf_q   <= ovf_d;
      inv_q   <= inv_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_data     = data_q;
  assign out_overflow = ovf_q;
  assign out_invalid  = inv_q;

endmodule

// File: tb/tb_bfloat_to_int.sv
// tb/tb_bfloat_to_int.sv - scoreboard bench for bfloat_to_int against an arithmetic reference
module tb_bfloat_to_int;
  localparam int INT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_data = 16'h0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [INT_W-1:0] out_data;
  logic             out_overflow;
  logic             out_invalid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bp_force = 0;

  typedef struct {
    logic [INT_W-1:0] data;
    logic             ovf;
    logic             inv;
    int               lat;
    int               t0;
  } exp_t;

  exp_t sbq[$];

  bfloat_to_int #(.INT_W(INT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_overflow(out_overflow), .out_invalid(out_invalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Value = M * 2^(e-134), rounded half-to-even with plain integer arithmetic.
  function automatic exp_t model(input logic [15:0] x);
    exp_t   r;
    int     e, m, k;
    longint mag, lim, q, rem, half;
    logic [63:0] d;
    e = int'(x[14:7]);
    m = 128 + int'(x[6:0]);
    lim = longint'(1) << (INT_W - 1);
    r.ovf = 1'b0; r.inv = 1'b0; r.lat = 1; r.t0 = 0; r.data = '0;
    if (e == 0) return r;
    if (e == 255 && x[6:0] != 0) begin
      r.inv = 1'b1;
      return r;
    end
    if (e == 255 || e - 134 > 40) begin
      mag = 2 * lim;
    end else if (e >= 134) begin
      mag = longint'(m) << (e - 134);
      r.lat = e - 134 + 2;
    end else begin
      k = 134 - e;
      r.lat = ((k < 9) ? k : 9) + 2;
      if (k >= 9) mag = 0;
      else begin
        q = longint'(m) >> k;
        rem = longint'(m) - (q << k);
        half = longint'(1) << (k - 1);
        mag = q + ((rem > half || (rem == half && q[0])) ? 1 : 0);
      end
    end
    if (mag >= lim) begin
      r.lat = 1;
      if (x[15] && mag == lim) d = 64'(-lim);
      else begin
        r.ovf = 1'b1;
        d = x[15] ? 64'(-lim) : 64'(lim - 1);
      end
    end else begin
      d = x[15] ? 64'(-mag) : 64'(mag);
    end
    r.data = d[INT_W-1:0];
    return r;
  endfunction

  task automatic send(input logic [15:0] x);
    exp_t e;
    int   guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
      return;
    end
    e = model(x);
    e.t0 = cyc;
    sbq.push_back(e);
    in_valid = 1'b1;
    in_data = x;
    @(negedge clk);
    in_valid = 1'b0;
    in_data = 16'($urandom);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sbq.size() != 0 || !in_ready) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", sbq.size());
    end
  endtask

  initial begin : monitor
    exp_t e;
    int   hold;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output actual=%0h required=none", out_data);
          out_ready = 1'b1;
        end else begin
          e = sbq.pop_front();
          chk("data", 32'(out_data), 32'(e.data));
          chk("overflow", 32'(out_overflow), 32'(e.ovf));
          chk("invalid", 32'(out_invalid), 32'(e.inv));
          chk("latency", 32'(cyc - e.t0), 32'(e.lat));
          hold = (bp_force != 0) ? bp_force : int'($urandom_range(0, 2));
          out_ready = 1'b0;
          for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(e.data));
            chk("hold_flags", 32'({out_overflow, out_invalid}), 32'({e.ovf, e.inv}));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
          end
          out_ready = 1'b1;
          @(negedge clk);
          out_ready = 1'b0;
          chk("release_valid", 32'(out_valid), 32'd0);
          chk("release_in_ready", 32'(in_ready), 32'd1);
          chk("release_flags", 32'({out_overflow, out_invalid}), 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [15:0] dir[12];
    logic [15:0] x;
    logic [7:0]  ex;
    int          sel;
    dir = '{16'h3FC0, 16'h3F40, 16'h4020, 16'hC020, 16'h3F00, 16'h46FF,
            16'hC700, 16'h4700, 16'h7FC0, 16'hFF80, 16'h0001, 16'h8000};
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_flags", 32'({out_overflow, out_invalid}), 32'd0);
    rst_n = 1'b1;

    foreach (dir[i]) send(dir[i]);
    drain();

    bp_force = 5;
    send(16'h3FC0);
    drain();
    bp_force = 0;

    send(16'h46FF);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    void'(sbq.pop_back());
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_data", 32'(out_data), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    send(16'h3FC0);
    drain();

    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0) ex = 8'd0;
      else if (sel == 1) ex = 8'hFF;
      else if (sel == 2) ex = 8'($urandom_range(1, 254));
      else ex = 8'($urandom_range(110, 145));
      x = {1'($urandom), ex, 7'($urandom)};
      send(x);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
